// File: rtl/command_encoder.sv
// command_encoder: transmit side of the 3-byte SPI command link.
// Requests are encoded to {cmd, db1, db2}, queued in a small FIFO and sent
// MSB first as SPI mode-0 master frames on sck/mosi/cs_n.
// Optional feature macro: DROP_DUP_SCORE_EN (drop score requests equal to the
// last enqueued score value).
module command_encoder #(
    parameter int FIFO_DEPTH = 4,
    parameter int CLK_DIV    = 2,
    parameter int GAP_CYCLES = 4
) (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic       i_req_valid,
    output logic       o_req_ready,
    input  logic       i_req_kind,
    input  logic [9:0] i_req_addr,
    input  logic [2:0] i_req_color,
    input  logic [9:0] i_req_score,
    output logic       o_sck,
    output logic       o_mosi,
    output logic       o_cs_n,
    output logic       o_busy,
    output logic       o_frame_done
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int HW = $clog2(CLK_DIV + 1);
    localparam int GW = $clog2(GAP_CYCLES + 1);

    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
    localparam logic [HW-1:0] H_LAST   = HW'(CLK_DIV - 1);
    localparam logic [GW-1:0] G_LAST   = GW'(GAP_CYCLES - 1);
    localparam logic [4:0]    B_LAST   = 5'd23;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_SHIFT = 2'd2,
        ST_GAP   = 2'd3
    } state_t;

    // Build the 24-bit frame {cmd, db1, db2} for one request.
    function automatic logic [23:0] encode_req(
        input logic       kind,
        input logic [9:0] addr,
        input logic [2:0] color,
        input logic [9:0] score
    );
        logic [23:0] word;
        if (kind) begin
            word = {8'b1000_0000, 6'b00_0000, score[9:8], score[7:0]};
        end else begin
            word = {5'b0100_0, color, 3'b000, addr[9:5], 3'b000, addr[4:0]};
        end
        return word;
    endfunction

    // Registers
    state_t          r_state;
    logic [23:0]     r_mem [FIFO_DEPTH];
    logic [PW-1:0]   r_wr_ptr;
    logic [PW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic            r_req_ready;
    logic [23:0]     r_shift;
    logic [HW-1:0]   r_hcnt;
    logic [4:0]      r_bcnt;
    logic [GW-1:0]   r_gcnt;
    logic            r_sck;
    logic            r_mosi;
    logic            r_cs_n;
    logic            r_busy;
    logic            r_frame_done;

    // Next-state wires
    state_t          w_state_next;
    logic [CW-1:0]   w_count_next;
    logic [23:0]     w_shift_next;
    logic [HW-1:0]   w_hcnt_next;
    logic [4:0]      w_bcnt_next;
    logic [GW-1:0]   w_gcnt_next;
    logic            w_sck_next;
    logic            w_mosi_next;
    logic            w_cs_n_next;
    logic            w_frame_done_next;
    logic            w_accept;
    logic            w_push;
    logic            w_pop;
    logic [23:0]     w_head;

    assign w_accept = i_req_valid && r_req_ready;
    assign w_pop    = (r_state == ST_IDLE) && (r_count != {CW{1'b0}});
    assign w_head   = r_mem[r_rd_ptr];

`ifdef DROP_DUP_SCORE_EN
    logic [9:0] r_last_score;
    logic       w_dup;

    // A repeated score is accepted on the handshake but never queued.
    assign w_dup  = i_req_kind && (i_req_score == r_last_score);
    assign w_push = w_accept && !w_dup;

    // Track the most recently enqueued score value.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_last_score <= 10'd0;
        end else if (w_push && i_req_kind) begin
            r_last_score <= i_req_score;
        end else begin
            r_last_score <= r_last_score;
        end
    end
`else
    assign w_push = w_accept;
`endif

    // FIFO occupancy after this cycle's push/pop.
    always_comb begin
        w_count_next = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + CW'(1);
            2'b01:   w_count_next = r_count - CW'(1);
            default: w_count_next = r_count;
        endcase
    end

    // Frame sequencer: next state and next SPI pin values.
    always_comb begin
        w_state_next      = r_state;
        w_shift_next      = r_shift;
        w_hcnt_next       = r_hcnt;
        w_bcnt_next       = r_bcnt;
        w_gcnt_next       = r_gcnt;
        w_sck_next        = r_sck;
        w_mosi_next       = r_mosi;
        w_cs_n_next       = r_cs_n;
        w_frame_done_next = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_pop) begin
                    w_shift_next = w_head;
                    w_mosi_next  = w_head[23];
                    w_cs_n_next  = 1'b0;
                    w_sck_next   = 1'b0;
                    w_hcnt_next  = {HW{1'b0}};
                    w_bcnt_next  = 5'd0;
                    w_state_next = ST_SETUP;
                end else begin
                    w_cs_n_next  = 1'b1;
                    w_sck_next   = 1'b0;
                    w_mosi_next  = 1'b0;
                end
            end
            ST_SETUP: begin
                if (r_hcnt == H_LAST) begin
                    w_sck_next   = 1'b1;
                    w_hcnt_next  = {HW{1'b0}};
                    w_state_next = ST_SHIFT;
                end else begin
                    w_hcnt_next  = r_hcnt + HW'(1);
                end
            end
            ST_SHIFT: begin
                if (r_hcnt == H_LAST) begin
                    w_hcnt_next = {HW{1'b0}};
                    if (r_sck) begin
                        if (r_bcnt == B_LAST) begin
                            // Last high phase ends the frame on this edge.
                            w_sck_next        = 1'b0;
                            w_cs_n_next       = 1'b1;
                            w_mosi_next       = 1'b0;
                            w_frame_done_next = 1'b1;
                            w_gcnt_next       = {GW{1'b0}};
                            w_state_next      = ST_GAP;
                        end else begin
                            // Falling sck: present the next bit (rotate keeps all bits live).
                            w_sck_next   = 1'b0;
                            w_shift_next = {r_shift[22:0], r_shift[23]};
                            w_mosi_next  = r_shift[22];
                            w_bcnt_next  = r_bcnt + 5'd1;
                        end
                    end else begin
                        w_sck_next = 1'b1;
                    end
                end else begin
                    w_hcnt_next = r_hcnt + HW'(1);
                end
            end
            ST_GAP: begin
                if (r_gcnt == G_LAST) begin
                    w_state_next = ST_IDLE;
                end else begin
                    w_gcnt_next  = r_gcnt + GW'(1);
                end
            end
            default: begin
                w_state_next = ST_IDLE;
                w_sck_next   = 1'b0;
                w_mosi_next  = 1'b0;
                w_cs_n_next  = 1'b1;
            end
        endcase
    end

    // FIFO storage write; contents need no reset since occupancy is reset.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= encode_req(i_req_kind, i_req_addr, i_req_color, i_req_score);
        end
    end

    // State, FIFO pointers and registered outputs.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_state      <= ST_IDLE;
            r_wr_ptr     <= {PW{1'b0}};
            r_rd_ptr     <= {PW{1'b0}};
            r_count      <= {CW{1'b0}};
            r_req_ready  <= 1'b1;
            r_shift      <= 24'd0;
            r_hcnt       <= {HW{1'b0}};
            r_bcnt       <= 5'd0;
            r_gcnt       <= {GW{1'b0}};
            r_sck        <= 1'b0;
            r_mosi       <= 1'b0;
            r_cs_n       <= 1'b1;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_wr_ptr     <= w_push ? r_wr_ptr + PW'(1) : r_wr_ptr;
            r_rd_ptr     <= w_pop ? r_rd_ptr + PW'(1) : r_rd_ptr;
            r_count      <= w_count_next;
            r_req_ready  <= (w_count_next != FULL_CNT);
            r_shift      <= w_shift_next;
            r_hcnt       <= w_hcnt_next;
            r_bcnt       <= w_bcnt_next;
            r_gcnt       <= w_gcnt_next;
            r_sck        <= w_sck_next;
            r_mosi       <= w_mosi_next;
            r_cs_n       <= w_cs_n_next;
            r_busy       <= (w_state_next != ST_IDLE) || (w_count_next != {CW{1'b0}});
            r_frame_done <= w_frame_done_next;
        end
    end

    assign o_req_ready  = r_req_ready;
    assign o_sck        = r_sck;
    assign o_mosi       = r_mosi;
    assign o_cs_n       = r_cs_n;
    assign o_busy       = r_busy;
    assign o_frame_done = r_frame_done;

endmodule
